// File: rtl/de3d_tc_pkg.sv
// Shared types for the texture-cache return path: swizzle encodings and the
// per-quad control entry carried through the gather FIFO.
package de3d_tc_pkg;

  localparam int TW_DEFAULT = 32;
  localparam int SWZ_W      = 2;
  localparam int CLAMP_W    = 4;
  localparam int MIP_W      = 4;
  localparam int BPT_W      = 3;
  localparam int TFMT_W     = 5;

  // {UL x-parity, UL y-parity}
  typedef enum logic [SWZ_W-1:0] {
    SWZ_00 = 2'b00,
    SWZ_01 = 2'b01,
    SWZ_10 = 2'b10,
    SWZ_11 = 2'b11
  } swz_e;

  // clamp bit order: [0]=UL, [1]=UR, [2]=LL, [3]=LR
  typedef struct packed {
    swz_e                swz;
    logic [CLAMP_W-1:0]  clamp;
    logic                clip;
    logic                exact;
    logic [MIP_W-1:0]    mipmap;
    logic [BPT_W-1:0]    bpt;
    logic [TFMT_W-1:0]   tfmt;
    logic                pal_mode;
  } ctl_entry_t;

  localparam int CTL_W = $bits(ctl_entry_t);

endpackage

// File: rtl/de3d_tc_ctl_fifo.sv
// Generic synchronous FIFO with combinational read of the head entry so a pop
// and its data land in the same cycle. Flags are registered from next-count.
module de3d_tc_ctl_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q;
  logic          do_push, do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_q;
  assign do_push = push_i & (~full_q | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/de3d_tc_texel_gather.sv
// Gathers parity-bank read data back into UL/UR/LL/LR order, applies exact
// duplication and clamp-to-border, and registers one quad per handshake.
module de3d_tc_texel_gather
  import de3d_tc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TW    = TW_DEFAULT
) (
  input  logic              de_clk,
  input  logic              de_rst,
  input  logic              push_uv_dd,
  input  logic [1:0]        swz_sel,
  input  logic              clamp_ul,
  input  logic              clamp_ur,
  input  logic              clamp_ll,
  input  logic              clamp_lr,
  input  logic              current_clip_dd,
  input  logic              current_exact_dd,
  input  logic [MIP_W-1:0]  current_mipmap_dd,
  input  logic [BPT_W-1:0]  bpt_dd,
  input  logic [TFMT_W-1:0] tfmt_dd,
  input  logic              pal_mode_dd,
  input  logic [TW-1:0]     border_color,
  input  logic              bank_vld,
  input  logic [TW-1:0]     ee_data,
  input  logic [TW-1:0]     eo_data,
  input  logic [TW-1:0]     oe_data,
  input  logic [TW-1:0]     oo_data,
  output logic              bank_rdy,
  output logic              uv_busy,
  output logic              texel_vld,
  input  logic              texel_ack,
  output logic [TW-1:0]     ul_t,
  output logic [TW-1:0]     ur_t,
  output logic [TW-1:0]     ll_t,
  output logic [TW-1:0]     lr_t,
  output logic              t_clip,
  output logic [MIP_W-1:0]  t_mipmap,
  output logic [BPT_W-1:0]  t_bpt,
  output logic [TFMT_W-1:0] t_tfmt,
  output logic              t_pal_mode,
  output logic              ord_err
);

  ctl_entry_t       push_entry, rd_entry;
  logic [CTL_W-1:0] fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic             bank_beat, load;
  logic             texel_vld_q;
  logic             ord_err_q, ord_err_d;
  logic [TW-1:0]    uns      [4];
  logic [TW-1:0]    gathered [4];
  logic [TW-1:0]    texel_q  [4];
  ctl_entry_t       sb_q;

  always_comb begin
    push_entry          = '0;
    push_entry.swz      = swz_e'(swz_sel);
    push_entry.clamp    = {clamp_lr, clamp_ll, clamp_ur, clamp_ul};
    push_entry.clip     = current_clip_dd;
    push_entry.exact    = current_exact_dd;
    push_entry.mipmap   = current_mipmap_dd;
    push_entry.bpt      = bpt_dd;
    push_entry.tfmt     = tfmt_dd;
    push_entry.pal_mode = pal_mode_dd;
  end

  assign bank_rdy  = ~texel_vld_q | texel_ack;
  assign bank_beat = bank_vld & bank_rdy;
  // Orphan bank data is flagged, never loaded.
  assign load      = bank_beat & ~fifo_empty;

  de3d_tc_ctl_fifo #(
    .DEPTH (DEPTH),
    .W     (CTL_W)
  ) u_ctl_fifo (
    .clk     (de_clk),
    .srst    (de_rst),
    .push_i  (push_uv_dd),
    .wdata_i (push_entry),
    .pop_i   (load),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rd_entry = ctl_entry_t'(fifo_rdata);

  // Index order of uns/gathered/texel_q: 0=UL, 1=UR, 2=LL, 3=LR.
  always_comb begin
    uns[0] = ee_data;
    uns[1] = oe_data;
    uns[2] = eo_data;
    uns[3] = oo_data;
    case (rd_entry.swz)
      SWZ_01: begin
        uns[0] = eo_data; uns[1] = oo_data; uns[2] = ee_data; uns[3] = oe_data;
      end
      SWZ_10: begin
        uns[0] = oe_data; uns[1] = ee_data; uns[2] = oo_data; uns[3] = eo_data;
      end
      SWZ_11: begin
        uns[0] = oo_data; uns[1] = eo_data; uns[2] = oe_data; uns[3] = ee_data;
      end
      default: ;
    endcase
  end

  assign ord_err_d = ord_err_q
                   | (bank_vld & fifo_empty)
                   | (push_uv_dd & fifo_full & ~load);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_texel
      // Clamp overrides exact duplication of the unswizzled UL texel.
      assign gathered[gi] = rd_entry.clamp[gi] ? border_color :
                            (((gi != 0) && rd_entry.exact) ? uns[0] : uns[gi]);

      always_ff @(posedge de_clk) begin
        if (de_rst)    texel_q[gi] <= '0;
        else if (load) texel_q[gi] <= gathered[gi];
      end
    end
  endgenerate

  always_ff @(posedge de_clk) begin
    if (de_rst) begin
      texel_vld_q <= 1'b0;
      sb_q        <= '0;
      ord_err_q   <= 1'b0;
    end else begin
      if (load) begin
        texel_vld_q <= 1'b1;
        sb_q        <= rd_entry;
      end else if (texel_ack) begin
        texel_vld_q <= 1'b0;
      end
      ord_err_q <= ord_err_d;
    end
  end

  assign texel_vld  = texel_vld_q;
  assign uv_busy    = fifo_full;
  assign ord_err    = ord_err_q;
  assign ul_t       = texel_q[0];
  assign ur_t       = texel_q[1];
  assign ll_t       = texel_q[2];
  assign lr_t       = texel_q[3];
  assign t_clip     = sb_q.clip;
  assign t_mipmap   = sb_q.mipmap;
  assign t_bpt      = sb_q.bpt;
  assign t_tfmt     = sb_q.tfmt;
  assign t_pal_mode = sb_q.pal_mode;

endmodule

// File: tb/tb_de3d_tc_texel_gather.sv
// Directed bench for the texel gather stage: a control/expected-quad scoreboard
// is filled as stimulus is driven and drained as quads are accepted.
module tb_de3d_tc_texel_gather;

  logic        de_clk = 1'b0;
  logic        de_rst;
  logic        push_uv_dd;
  logic [1:0]  swz_sel;
  logic        clamp_ul, clamp_ur, clamp_ll, clamp_lr;
  logic        current_clip_dd, current_exact_dd;
  logic [3:0]  current_mipmap_dd;
  logic [2:0]  bpt_dd;
  logic [4:0]  tfmt_dd;
  logic        pal_mode_dd;
  logic [31:0] border_color;
  logic        bank_vld;
  logic [31:0] ee_data, eo_data, oe_data, oo_data;
  logic        bank_rdy, uv_busy, texel_vld, texel_ack;
  logic [31:0] ul_t, ur_t, ll_t, lr_t;
  logic        t_clip;
  logic [3:0]  t_mipmap;
  logic [2:0]  t_bpt;
  logic [4:0]  t_tfmt;
  logic        t_pal_mode;
  logic        ord_err;

  always #5 de_clk = ~de_clk;

  de3d_tc_texel_gather #(.DEPTH(4), .TW(32)) dut (
    .de_clk(de_clk), .de_rst(de_rst), .push_uv_dd(push_uv_dd), .swz_sel(swz_sel),
    .clamp_ul(clamp_ul), .clamp_ur(clamp_ur), .clamp_ll(clamp_ll), .clamp_lr(clamp_lr),
    .current_clip_dd(current_clip_dd), .current_exact_dd(current_exact_dd),
    .current_mipmap_dd(current_mipmap_dd), .bpt_dd(bpt_dd), .tfmt_dd(tfmt_dd),
    .pal_mode_dd(pal_mode_dd), .border_color(border_color), .bank_vld(bank_vld),
    .ee_data(ee_data), .eo_data(eo_data), .oe_data(oe_data), .oo_data(oo_data),
    .bank_rdy(bank_rdy), .uv_busy(uv_busy), .texel_vld(texel_vld), .texel_ack(texel_ack),
    .ul_t(ul_t), .ur_t(ur_t), .ll_t(ll_t), .lr_t(lr_t), .t_clip(t_clip),
    .t_mipmap(t_mipmap), .t_bpt(t_bpt), .t_tfmt(t_tfmt), .t_pal_mode(t_pal_mode),
    .ord_err(ord_err)
  );

  typedef struct packed {
    logic [1:0] swz;
    logic [3:0] clamp;
    logic       exact;
    logic       clip;
    logic [3:0] mip;
    logic [2:0] bpt;
    logic [4:0] tfmt;
    logic       pal;
  } ctl_t;

  typedef struct packed {
    logic [3:0][31:0] q;
    logic [13:0]      sb;
  } quad_t;

  ctl_t  ctl_q[$];
  quad_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    seq = 0;
  int    cycles;
  time   t0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge de_clk);
    #1;
  endtask

  // Drives one control push for the coming edge; model_it=0 for a push the DUT must drop.
  task automatic drive_push(input logic [1:0] sel, input logic [3:0] cl, input logic ex,
                            input bit model_it);
    ctl_t c;
    c.swz = sel; c.clamp = cl; c.exact = ex;
    c.clip = seq[1]; c.mip = seq[3:0]; c.bpt = seq[2:0] ^ 3'd5;
    c.tfmt = seq[4:0] + 5'd3; c.pal = ~seq[0];
    seq++;
    push_uv_dd = 1'b1; swz_sel = c.swz;
    {clamp_lr, clamp_ll, clamp_ur, clamp_ul} = c.clamp;
    current_exact_dd = c.exact; current_clip_dd = c.clip; current_mipmap_dd = c.mip;
    bpt_dd = c.bpt; tfmt_dd = c.tfmt; pal_mode_dd = c.pal;
    if (model_it) ctl_q.push_back(c);
  endtask

  task automatic push_q(input logic [1:0] sel, input logic [3:0] cl, input logic ex);
    drive_push(sel, cl, ex, 1'b1);
    tick();
    push_uv_dd = 1'b0;
  endtask

  task automatic model_beat();
    ctl_t        c;
    quad_t       r;
    logic [31:0] t[4];
    if (ctl_q.size() == 0) begin
      chk("model_ctl_underflow", 64'(ctl_q.size()), 64'd1);
      return;
    end
    c = ctl_q.pop_front();
    case (c.swz)
      2'd0:    t = '{ee_data, oe_data, eo_data, oo_data};
      2'd1:    t = '{eo_data, oo_data, ee_data, oe_data};
      2'd2:    t = '{oe_data, ee_data, oo_data, eo_data};
      default: t = '{oo_data, eo_data, oe_data, ee_data};
    endcase
    if (c.exact) begin
      t[1] = t[0]; t[2] = t[0]; t[3] = t[0];
    end
    for (int i = 0; i < 4; i++) begin
      if (c.clamp[i]) t[i] = border_color;
      r.q[i] = t[i];
    end
    r.sb = {c.clip, c.mip, c.bpt, c.tfmt, c.pal};
    exp_q.push_back(r);
  endtask

  // Presents bank data and waits (bounded) for the beat; leaves bank_vld high.
  task automatic beat(input logic [31:0] ee, input logic [31:0] eo,
                      input logic [31:0] oe, input logic [31:0] oo);
    bit ok = 1'b0;
    bank_vld = 1'b1; ee_data = ee; eo_data = eo; oe_data = oe; oo_data = oo;
    for (int i = 0; i < 20; i++) begin
      @(negedge de_clk);
      if (bank_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("beat_wait", 64'(ok), 64'd1);
    if (ok) begin
      model_beat();
      tick();
    end
  endtask

  always @(negedge de_clk) begin : monitor
    quad_t e;
    if (!de_rst && texel_vld && texel_ack) begin
      if (exp_q.size() == 0) begin
        chk("quad_without_expect", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("ul_t", 64'(ul_t), 64'(e.q[0]));
        chk("ur_t", 64'(ur_t), 64'(e.q[1]));
        chk("ll_t", 64'(ll_t), 64'(e.q[2]));
        chk("lr_t", 64'(lr_t), 64'(e.q[3]));
        chk("sideband", 64'({t_clip, t_mipmap, t_bpt, t_tfmt, t_pal_mode}), 64'(e.sb));
        $display("quad: ul=%h ur=%h ll=%h lr=%h sb=%h", ul_t, ur_t, ll_t, lr_t,
                 {t_clip, t_mipmap, t_bpt, t_tfmt, t_pal_mode});
      end
    end
  end

  logic [31:0] hold_ul, hold_lr;

  initial begin
    de_rst = 1'b1; push_uv_dd = 1'b0; swz_sel = 2'b00;
    {clamp_lr, clamp_ll, clamp_ur, clamp_ul} = 4'b0;
    current_clip_dd = 1'b0; current_exact_dd = 1'b0; current_mipmap_dd = 4'd0;
    bpt_dd = 3'd0; tfmt_dd = 5'd0; pal_mode_dd = 1'b0;
    border_color = 32'hFFFF_0000; bank_vld = 1'b0;
    ee_data = '0; eo_data = '0; oe_data = '0; oo_data = '0; texel_ack = 1'b1;
    repeat (3) tick();
    de_rst = 1'b0;

    // reset state
    @(negedge de_clk);
    chk("rst_texel_vld", 64'(texel_vld), 64'd0);
    chk("rst_uv_busy", 64'(uv_busy), 64'd0);
    chk("rst_bank_rdy", 64'(bank_rdy), 64'd1);
    chk("rst_ord_err", 64'(ord_err), 64'd0);
    chk("rst_data", 64'({ul_t, lr_t}), 64'd0);
    chk("rst_sideband", 64'({t_clip, t_mipmap, t_bpt, t_tfmt, t_pal_mode}), 64'd0);
    tick();

    // swizzle: four selects, back-to-back beats with ack high
    for (int s = 0; s < 4; s++) push_q(2'(s), 4'b0000, 1'b0);
    t0 = $time;
    for (int s = 0; s < 4; s++) beat(32'd1, 32'd2, 32'd3, 32'd4);
    bank_vld = 1'b0;
    cycles = int'(($time - t0) / 10);
    chk("throughput_cycles", 64'(cycles), 64'd4);
    @(negedge de_clk);
    chk("latency_last_vld", 64'(texel_vld), 64'd1);
    tick();
    @(negedge de_clk);
    chk("drained_vld", 64'(texel_vld), 64'd0);
    tick();

    // clamp / exact
    push_q(2'd0, 4'b0101, 1'b0);
    push_q(2'd0, 4'b0000, 1'b1);
    push_q(2'd2, 4'b0010, 1'b1);
    for (int s = 0; s < 3; s++) beat(32'd1, 32'd2, 32'd3, 32'd4);
    bank_vld = 1'b0;
    tick();

    // backpressure: ack low for 5 cycles with bank_vld held
    texel_ack = 1'b0;
    push_q(2'd1, 4'b0000, 1'b0);
    push_q(2'd2, 4'b0000, 1'b0);
    beat(32'h5, 32'h6, 32'h7, 32'h8);
    hold_ul = exp_q[0].q[0];
    hold_lr = exp_q[0].q[3];
    for (int i = 0; i < 5; i++) begin
      @(negedge de_clk);
      chk("bp_bank_rdy", 64'(bank_rdy), 64'd0);
      chk("bp_texel_vld", 64'(texel_vld), 64'd1);
      chk("bp_ul_stable", 64'(ul_t), 64'(hold_ul));
      chk("bp_lr_stable", 64'(lr_t), 64'(hold_lr));
      tick();
    end
    texel_ack = 1'b1;
    @(negedge de_clk);
    chk("bp_release_rdy", 64'(bank_rdy), 64'd1);
    model_beat();
    tick();
    bank_vld = 1'b0;
    @(negedge de_clk);
    chk("bp_second_vld", 64'(texel_vld), 64'd1);
    tick();

    // full FIFO, discarded 5th push, push+pop while full
    for (int i = 0; i < 4; i++) push_q(2'(i), 4'b0000, 1'b0);
    @(negedge de_clk);
    chk("full_uv_busy", 64'(uv_busy), 64'd1);
    chk("full_no_err", 64'(ord_err), 64'd0);
    drive_push(2'd3, 4'b1111, 1'b0, 1'b0);
    tick();
    push_uv_dd = 1'b0;
    @(negedge de_clk);
    chk("overflow_ord_err", 64'(ord_err), 64'd1);
    chk("overflow_uv_busy", 64'(uv_busy), 64'd1);
    tick();
    drive_push(2'd1, 4'b1000, 1'b0, 1'b1);
    beat(32'd9, 32'd10, 32'd11, 32'd12);
    push_uv_dd = 1'b0;
    bank_vld = 1'b0;
    @(negedge de_clk);
    chk("push_pop_full_busy", 64'(uv_busy), 64'd1);
    tick();
    for (int i = 0; i < 4; i++) beat(32'h21 + 32'(i), 32'h31, 32'h41, 32'h51);
    bank_vld = 1'b0;
    tick();
    @(negedge de_clk);
    chk("drain_uv_busy", 64'(uv_busy), 64'd0);
    tick();

    // reset mid-stream: 3 entries queued and a quad held
    texel_ack = 1'b0;
    for (int i = 0; i < 4; i++) push_q(2'(i), 4'b0000, 1'b0);
    beat(32'd1, 32'd2, 32'd3, 32'd4);
    bank_vld = 1'b0;
    @(negedge de_clk);
    chk("pre_rst_vld", 64'(texel_vld), 64'd1);
    chk("pre_rst_err", 64'(ord_err), 64'd1);
    tick();
    de_rst = 1'b1;
    tick();
    de_rst = 1'b0;
    @(negedge de_clk);
    chk("mid_rst_vld", 64'(texel_vld), 64'd0);
    chk("mid_rst_busy", 64'(uv_busy), 64'd0);
    chk("mid_rst_err", 64'(ord_err), 64'd0);
    ctl_q.delete();
    exp_q.delete();
    tick();
    texel_ack = 1'b1;
    push_q(2'd3, 4'b0000, 1'b0);
    beat(32'h11, 32'h22, 32'h33, 32'h44);
    bank_vld = 1'b0;
    tick();

    // orphan bank data
    @(negedge de_clk);
    chk("orphan_pre_err", 64'(ord_err), 64'd0);
    tick();
    bank_vld = 1'b1;
    tick();
    bank_vld = 1'b0;
    @(negedge de_clk);
    chk("orphan_no_vld", 64'(texel_vld), 64'd0);
    chk("orphan_ord_err", 64'(ord_err), 64'd1);
    tick();

    // push and bank_vld in the same cycle into an empty FIFO: no bypass
    de_rst = 1'b1;
    tick();
    de_rst = 1'b0;
    tick();
    drive_push(2'd2, 4'b0000, 1'b0, 1'b1);
    bank_vld = 1'b1;
    tick();
    push_uv_dd = 1'b0;
    bank_vld = 1'b0;
    @(negedge de_clk);
    chk("nobypass_vld", 64'(texel_vld), 64'd0);
    chk("nobypass_ord_err", 64'(ord_err), 64'd1);
    tick();
    beat(32'hA, 32'hB, 32'hC, 32'hD);
    bank_vld = 1'b0;
    tick();
    tick();

    @(negedge de_clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
